// File: rtl/esfa_cell_sequencer_pkg.sv
// Shared constants and types for the ESFA cell sequencer: opcodes, cell
// selectors, the idle bus pattern, FSM states and the step-pattern builder.
package esfa_pkg;

  // Host command opcodes
  localparam logic [2:0] OP_LOOKUP = 3'd0;
  localparam logic [2:0] OP_ENCODE = 3'd1;
  localparam logic [2:0] OP_ENRANK = 3'd2;
  localparam logic [2:0] OP_ALLOC  = 3'd3;
  localparam logic [2:0] OP_INSERT = 3'd4;
  localparam logic [2:0] OP_DELETE = 3'd5;
  localparam logic [2:0] OP_DEBUG  = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  // Cell bus selectors
  localparam logic [7:0] SEL_UPDATE       = 8'd0;
  localparam logic [7:0] SEL_LOOKUP       = 8'd1;
  localparam logic [7:0] SEL_ENCODE       = 8'd2;
  localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
  localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
  localparam logic [7:0] SEL_MARK_AVAIL   = 8'd5;
  localparam logic [7:0] SEL_ENRANK       = 8'd6;
  localparam logic [7:0] SEL_DEBUG        = 8'd7;

  typedef struct packed {
    logic [7:0] selector;
    logic [7:0] metadata;
    logic       is_metadata;
    logic [7:0] index;
    logic [7:0] value;
  } bus_pat_t;

  // Read-only in every cell; steps always differ from it via is_metadata.
  localparam bus_pat_t IDLE_PATTERN = '{
    selector:    8'd1,
    metadata:    8'd0,
    is_metadata: 1'b0,
    index:       8'd0,
    value:       8'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_t;

  // Build the bus pattern for a given command step. alloc is the handle
  // won by the INSERT allocation step and is only used by INSERT steps 1/2.
  function automatic bus_pat_t step_pattern(
    input logic [2:0] op,
    input logic [1:0] step,
    input logic [7:0] handle,
    input logic [7:0] index,
    input logic [7:0] value,
    input logic [7:0] aux,
    input logic [7:0] alloc
  );
    bus_pat_t p;
    p             = IDLE_PATTERN;
    p.is_metadata = 1'b1;
    case (op)
      OP_LOOKUP: begin
        p.selector = SEL_LOOKUP;
        p.metadata = handle;
        p.index    = index;
      end
      OP_ENCODE: begin
        p.selector = SEL_ENCODE;
        p.metadata = handle;
      end
      OP_ENRANK: begin
        p.selector = SEL_ENRANK;
        p.metadata = handle;
      end
      OP_ALLOC: begin
        p.selector = SEL_MARK_AVAIL;
      end
      OP_DEBUG: begin
        p.selector = SEL_DEBUG;
        p.metadata = handle;
      end
      OP_DELETE: begin
        p.selector = SEL_CONGRUE_DOWN;
        p.metadata = handle;
        p.index    = index;
      end
      OP_INSERT: begin
        case (step)
          2'd0: begin
            p.selector = SEL_MARK_AVAIL;
          end
          2'd1: begin
            p.selector = SEL_UPDATE;
            p.metadata = alloc;
            p.index    = index;
            p.value    = value;
          end
          default: begin
            p.selector = SEL_CONGRUE_UP;
            p.metadata = handle;
            p.index    = alloc;
            p.value    = aux;
          end
        endcase
      end
      default: begin
        p = IDLE_PATTERN;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/esfa_cell_sequencer_hit_select.sv
// Priority encoder and mux over the cell outputs: the lowest-numbered
// hitting cell supplies result and context; with no hit everything is 0.
module esfa_hit_select #(
  parameter int N_CELLS = 8
) (
  input  logic [N_CELLS-1:0]   cell_bool,
  input  logic [8*N_CELLS-1:0] cell_result,
  input  logic [8*N_CELLS-1:0] cell_context,
  output logic                 any_hit,
  output logic [7:0]           winner,
  output logic [7:0]           winner_result,
  output logic [7:0]           winner_context
);

  // Scan from the top down so the lowest-numbered hitting cell is written last.
  always_comb begin
    any_hit        = |cell_bool;
    winner         = 8'd0;
    winner_result  = 8'd0;
    winner_context = 8'd0;
    for (int k = N_CELLS - 1; k >= 0; k--) begin
      winner         = cell_bool[k] ? 8'(k)                     : winner;
      winner_result  = cell_bool[k] ? cell_result[8*k +: 8]     : winner_result;
      winner_context = cell_bool[k] ? cell_context[8*k +: 8]    : winner_context;
    end
  end

endmodule

// File: rtl/esfa_cell_sequencer.sv
// ESFA cell sequencer: expands one host command into single-cycle broadcast
// steps on the cell bus, captures the cells' registered outputs after each
// readable step and returns one prioritised response.
module esfa_cell_sequencer
  import esfa_pkg::*;
#(
  parameter int N_CELLS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [7:0]           cmd_handle,
  input  logic [7:0]           cmd_index,
  input  logic [7:0]           cmd_value,
  input  logic [7:0]           cmd_aux,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic                 rsp_err,
  output logic [7:0]           rsp_value,
  output logic [7:0]           rsp_context,
  output logic [7:0]           bus_selector,
  output logic [7:0]           bus_metadata,
  output logic                 bus_is_metadata,
  output logic [7:0]           bus_index,
  output logic [7:0]           bus_value,
  input  logic [N_CELLS-1:0]   cell_bool,
  input  logic [8*N_CELLS-1:0] cell_result,
  input  logic [8*N_CELLS-1:0] cell_context
);

  seq_state_t state_r, state_s;
  logic [2:0] op_r, op_s;
  logic [7:0] handle_r, handle_s;
  logic [7:0] index_r, index_s;
  logic [7:0] value_r, value_s;
  logic [7:0] aux_r, aux_s;
  logic [1:0] step_r, step_s;
  logic [7:0] alloc_r, alloc_s;
  bus_pat_t   bus_r, bus_s;
  logic       rsp_valid_r, rsp_valid_s;
  logic       rsp_hit_r, rsp_hit_s;
  logic       rsp_err_r, rsp_err_s;
  logic [7:0] rsp_value_r, rsp_value_s;
  logic [7:0] rsp_context_r, rsp_context_s;

  logic       any_hit_s;
  logic [7:0] winner_s;
  logic [7:0] winner_result_s;
  logic [7:0] winner_context_s;

  esfa_hit_select #(
    .N_CELLS(N_CELLS)
  ) u_hit_select (
    .cell_bool      (cell_bool),
    .cell_result    (cell_result),
    .cell_context   (cell_context),
    .any_hit        (any_hit_s),
    .winner         (winner_s),
    .winner_result  (winner_result_s),
    .winner_context (winner_context_s)
  );

  // Next-state, next-bus and next-response logic; every register holds by default.
  always_comb begin
    state_s       = state_r;
    op_s          = op_r;
    handle_s      = handle_r;
    index_s       = index_r;
    value_s       = value_r;
    aux_s         = aux_r;
    step_s        = step_r;
    alloc_s       = alloc_r;
    bus_s         = bus_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_hit_s     = rsp_hit_r;
    rsp_err_s     = rsp_err_r;
    rsp_value_s   = rsp_value_r;
    rsp_context_s = rsp_context_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_s     = cmd_op;
          handle_s = cmd_handle;
          index_s  = cmd_index;
          value_s  = cmd_value;
          aux_s    = cmd_aux;
          step_s   = 2'd0;
          alloc_s  = 8'd0;
          if (cmd_op == OP_RSVD) begin
            // Reserved opcode never touches the bus.
            state_s       = ST_RESP;
            rsp_valid_s   = 1'b1;
            rsp_hit_s     = 1'b0;
            rsp_err_s     = 1'b1;
            rsp_value_s   = 8'd0;
            rsp_context_s = 8'd0;
          end else begin
            state_s = ST_ISSUE;
            bus_s   = step_pattern(cmd_op, 2'd0, cmd_handle, cmd_index,
                                   cmd_value, cmd_aux, 8'd0);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A step is held for exactly one cycle: cells repeat writes while it is held.
        state_s = ST_CAPTURE;
        bus_s   = IDLE_PATTERN;
      end
      ST_CAPTURE: begin
        if ((op_r == OP_INSERT) && (step_r == 2'd0) && any_hit_s) begin
          alloc_s = winner_s;
          step_s  = 2'd1;
          state_s = ST_ISSUE;
          bus_s   = step_pattern(op_r, 2'd1, handle_r, index_r, value_r,
                                 aux_r, winner_s);
        end else if ((op_r == OP_INSERT) && (step_r == 2'd1)) begin
          step_s  = 2'd2;
          state_s = ST_ISSUE;
          bus_s   = step_pattern(op_r, 2'd2, handle_r, index_r, value_r,
                                 aux_r, alloc_r);
        end else begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          if ((op_r == OP_INSERT) && (step_r == 2'd2)) begin
            // Last INSERT step is write-only; report the allocated handle.
            rsp_hit_s     = 1'b1;
            rsp_value_s   = alloc_r;
            rsp_context_s = 8'd0;
          end else if (op_r == OP_DELETE) begin
            // Cells hold stale flags on a write-only step; ignore them.
            rsp_hit_s     = 1'b1;
            rsp_value_s   = 8'd0;
            rsp_context_s = 8'd0;
          end else begin
            rsp_hit_s     = any_hit_s;
            rsp_value_s   = winner_result_s;
            rsp_context_s = winner_context_s;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        bus_s       = IDLE_PATTERN;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State, latched command, bus and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      op_r          <= 3'd0;
      handle_r      <= 8'd0;
      index_r       <= 8'd0;
      value_r       <= 8'd0;
      aux_r         <= 8'd0;
      step_r        <= 2'd0;
      alloc_r       <= 8'd0;
      bus_r         <= IDLE_PATTERN;
      rsp_valid_r   <= 1'b0;
      rsp_hit_r     <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_value_r   <= 8'd0;
      rsp_context_r <= 8'd0;
    end else begin
      state_r       <= state_s;
      op_r          <= op_s;
      handle_r      <= handle_s;
      index_r       <= index_s;
      value_r       <= value_s;
      aux_r         <= aux_s;
      step_r        <= step_s;
      alloc_r       <= alloc_s;
      bus_r         <= bus_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_hit_r     <= rsp_hit_s;
      rsp_err_r     <= rsp_err_s;
      rsp_value_r   <= rsp_value_s;
      rsp_context_r <= rsp_context_s;
    end
  end

  assign cmd_ready       = (state_r == ST_IDLE);
  assign rsp_valid       = rsp_valid_r;
  assign rsp_hit         = rsp_hit_r;
  assign rsp_err         = rsp_err_r;
  assign rsp_value       = rsp_value_r;
  assign rsp_context     = rsp_context_r;
  assign bus_selector    = bus_r.selector;
  assign bus_metadata    = bus_r.metadata;
  assign bus_is_metadata = bus_r.is_metadata;
  assign bus_index       = bus_r.index;
  assign bus_value       = bus_r.value;

endmodule
